// File: rtl/fir_pipelined_tree.sv
// Streaming direct-form FIR: registered products, registered binary adder tree,
// then a round-half-up stage and a saturating output stage, with a valid tag alongside.
module fir_pipelined_tree #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 53,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned FRAC_BITS = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat
);

  localparam int unsigned LEVELS  = $clog2(TAPS);
  localparam int unsigned TREE_N  = 2 ** LEVELS;
  localparam int unsigned PROD_W  = DATA_W + COEF_W;
  localparam int unsigned ACC_W   = DATA_W + COEF_W + LEVELS;
  localparam int unsigned AW      = $clog2(TAPS);
  // Rounded value is kept wide enough to hold both the full sum and the output limits.
  localparam int unsigned RW      = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam int unsigned HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic signed [ACC_W:0] HALF =
      (FRAC_BITS > 0) ? ({{ACC_W{1'b0}}, 1'b1} << HALF_SH) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] d_q    [TAPS];
  logic signed [DATA_W-1:0] d_d    [TAPS];
  logic signed [COEF_W-1:0] h_q    [TAPS];
  logic signed [COEF_W-1:0] h_d    [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [ACC_W-1:0]  node_q [1:TREE_N-1];
  logic signed [ACC_W-1:0]  node_d [1:TREE_N-1];
  // Heap layout: node i sums entries 2i and 2i+1; entries TREE_N.. are the product leaves.
  logic signed [ACC_W-1:0]  heap   [2:2*TREE_N-1];
  logic [LEVELS+3:0]        vld_q;
  logic signed [RW-1:0]     rnd_q, rnd_d;
  logic signed [ACC_W:0]    sum_x, sum_r;
  logic signed [OUT_W-1:0]  out_d;
  logic                     sat_d;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    if (k == 0) begin : g_head
      assign d_d[k] = in_data;
    end else begin : g_shift
      assign d_d[k] = d_q[k-1];
    end
    assign h_d[k]    = (coef_we && coef_addr == AW'(k)) ? coef_wdata : h_q[k];
    assign prod_d[k] = PROD_W'(h_q[k]) * PROD_W'(d_q[k]);
  end

  for (genvar j = 0; j < TREE_N; j++) begin : g_leaf
    if (j < TAPS) begin : g_prod
      assign heap[TREE_N+j] = ACC_W'(prod_q[j]);
    end else begin : g_zero
      assign heap[TREE_N+j] = '0;
    end
  end

  for (genvar i = 1; i < TREE_N; i++) begin : g_node
    if (i >= 2) begin : g_inner
      assign heap[i] = node_q[i];
    end
    assign node_d[i] = heap[2*i] + heap[2*i+1];
  end

  assign sum_x = $signed({node_q[1][ACC_W-1], node_q[1]});
  assign sum_r = (sum_x + HALF) >>> FRAC_BITS;
  assign rnd_d = RW'(sum_r);

  always_comb begin
    out_d = rnd_q[OUT_W-1:0];
    sat_d = 1'b0;
    if (rnd_q > SAT_MAX) begin
      out_d = OUT_MAX;
      sat_d = 1'b1;
    end else if (rnd_q < SAT_MIN) begin
      out_d = OUT_MIN;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q      <= '{default: '0};
      h_q      <= '{default: '0};
      prod_q   <= '{default: '0};
      node_q   <= '{default: '0};
      vld_q    <= '0;
      rnd_q    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (in_valid) begin
        d_q <= d_d;
      end
      h_q    <= h_d;
      prod_q <= prod_d;
      node_q <= node_d;
      vld_q  <= {vld_q[LEVELS+2:0], in_valid};
      rnd_q  <= rnd_d;
      if (vld_q[LEVELS+2]) begin
        out_data <= out_d;
        out_sat  <= sat_d;
      end
    end
  end

  assign out_valid = vld_q[LEVELS+3];

endmodule

// File: tb/tb_fir_pipelined_tree.sv
// Directed bench: a 5-tap wide-output instance (impulse, bubbles, coefficient
// writes, mid-stream reset) and a default instance (rounding, saturation).
module tb_fir_pipelined_tree;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance: TAPS=5, FRAC_BITS=0, OUT_W=40
  logic               s_in_valid, s_coef_we, s_out_valid, s_out_sat;
  logic signed [15:0] s_in_data, s_coef_wdata;
  logic [2:0]         s_coef_addr;
  logic signed [39:0] s_out_data;

  // Default instance
  logic               d_in_valid, d_coef_we, d_out_valid, d_out_sat;
  logic signed [15:0] d_in_data, d_coef_wdata, d_out_data;
  logic [5:0]         d_coef_addr;

  fir_pipelined_tree #(
    .DATA_W(16), .COEF_W(16), .TAPS(5), .OUT_W(40), .FRAC_BITS(0)
  ) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
    .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_wdata(s_coef_wdata),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sat(s_out_sat)
  );

  fir_pipelined_tree u_dflt (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_data(d_in_data),
    .coef_we(d_coef_we), .coef_addr(d_coef_addr), .coef_wdata(d_coef_wdata),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_sat(d_out_sat)
  );

  longint s_q[$];
  int     s_t[$];
  longint d_q[$];
  logic   d_s[$];
  int     d_t[$];

  always @(negedge clk) begin
    if (s_out_valid === 1'b1) begin
      s_q.push_back(longint'(s_out_data));
      s_t.push_back(cyc);
    end
    if (d_out_valid === 1'b1) begin
      d_q.push_back(longint'(d_out_data));
      d_s.push_back(d_out_sat);
      d_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int     t0;
  int     exp_t[$];
  longint exp1[10] = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0};
  longint exp5[16] = '{1, 2, 3, 4, 5, 0, 0, 0, 1, 2, 7, 4, 5, 0, 0, 0};
  longint exp3[3]  = '{2, -1, 1};

  initial begin
    reset = 1'b1;
    s_in_valid = 0; s_in_data = '0; s_coef_we = 0; s_coef_addr = '0; s_coef_wdata = '0;
    d_in_valid = 0; d_in_data = '0; d_coef_we = 0; d_coef_addr = '0; d_coef_wdata = '0;
    tick(3);
    chk("rst_s_valid", s_out_valid, 0);
    chk("rst_s_data", s_out_data, 0);
    chk("rst_s_sat", s_out_sat, 0);
    chk("rst_d_valid", d_out_valid, 0);
    chk("rst_d_data", d_out_data, 0);
    chk("rst_d_sat", d_out_sat, 0);
    reset = 1'b0;
    tick(1);

    // T1 impulse
    for (int k = 0; k < 5; k++) begin
      s_coef_we = 1; s_coef_addr = 3'(k); s_coef_wdata = 16'(k + 1);
      tick(1);
    end
    s_coef_we = 0;
    s_q.delete(); s_t.delete();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      s_in_valid = 1; s_in_data = (i == 0) ? 16'sd1 : 16'sd0;
      tick(1);
    end
    s_in_valid = 0;
    tick(10);
    chk("t1_count", s_q.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t1_y%0d", i), s_q[i], exp1[i]);
    chk("t1_first_lat", s_t[0], t0 + 7);
    chk("t1_last_lat", s_t[9], t0 + 16);

    // T2 bubbles: bubble data is junk and must not shift in
    s_q.delete(); s_t.delete();
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1; s_in_data = (i == 0) ? 16'sd1 : 16'sd0;
      exp_t.push_back(cyc);
      tick(1);
      s_in_valid = 0; s_in_data = 16'sh7777;
      tick(1);
    end
    s_in_data = '0;
    tick(10);
    chk("t2_count", s_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_y%0d", i), s_q[i], exp1[i]);
      chk($sformatf("t2_lat%0d", i), s_t[i], exp_t[i] + 7);
    end

    // T5 coef writes mid-stream: out-of-range addr 5 first, then h[2]=7
    s_q.delete(); s_t.delete();
    for (int c = 0; c < 16; c++) begin
      s_in_valid   = 1;
      s_in_data    = (c == 0 || c == 8) ? 16'sd1 : 16'sd0;
      s_coef_we    = (c == 1 || c == 3);
      s_coef_addr  = (c == 1) ? 3'd5 : 3'd2;
      s_coef_wdata = (c == 1) ? 16'sd99 : 16'sd7;
      tick(1);
    end
    s_in_valid = 0; s_coef_we = 0;
    tick(10);
    chk("t5_count", s_q.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t5_y%0d", i), s_q[i], exp5[i]);

    // T6 reset with the pipeline full
    for (int c = 0; c < 8; c++) begin
      s_in_valid = 1; s_in_data = 16'sd1;
      tick(1);
    end
    s_in_valid = 0;
    chk("t6_pre_valid", s_out_valid, 1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_valid", s_out_valid, 0);
    chk("t6_rst_data", s_out_data, 0);
    chk("t6_rst_sat", s_out_sat, 0);
    s_q.delete(); s_t.delete();
    reset = 1'b0;
    tick(12);
    chk("t6_no_valid", s_q.size(), 0);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1; s_in_data = (i == 0) ? 16'sd1 : 16'sd0;
      tick(1);
    end
    s_in_valid = 0;
    tick(10);
    chk("t6_count", s_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t6_y%0d", i), s_q[i], 0);
    chk("t6_lat", s_t[0], t0 + 7);

    // T3 rounding on defaults, h[0]=0.5
    d_coef_we = 1; d_coef_addr = 6'd0; d_coef_wdata = 16'sd16384;
    tick(1);
    d_coef_we = 0;
    d_q.delete(); d_s.delete(); d_t.delete();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      d_in_valid = 1;
      d_in_data  = (i == 0) ? 16'sd3 : (i == 1) ? -16'sd3 : 16'sd2;
      tick(1);
    end
    d_in_valid = 0;
    tick(12);
    chk("t3_count", d_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_y%0d", i), d_q[i], exp3[i]);
      chk($sformatf("t3_sat%0d", i), d_s[i], 0);
    end
    chk("t3_lat", d_t[0], t0 + 10);

    // T4 saturation: all h full scale, steady full-scale inputs
    for (int k = 0; k < 53; k++) begin
      d_coef_we = 1; d_coef_addr = 6'(k); d_coef_wdata = 16'sd32767;
      tick(1);
    end
    d_coef_we = 0;
    d_q.delete(); d_s.delete(); d_t.delete();
    for (int i = 0; i < 120; i++) begin
      d_in_valid = 1;
      d_in_data  = (i < 60) ? 16'sd32767 : 16'sh8000;
      tick(1);
    end
    d_in_valid = 0;
    tick(12);
    chk("t4_count", d_q.size(), 120);
    chk("t4_pos_y", d_q[59], 32767);
    chk("t4_pos_sat", d_s[59], 1);
    chk("t4_neg_y", d_q[119], -32768);
    chk("t4_neg_sat", d_s[119], 1);
    chk("t4_hold_valid", d_out_valid, 0);
    chk("t4_hold_data", d_out_data, -32768);
    chk("t4_hold_sat", d_out_sat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
